// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine between the multicycle control FSM and a
// synchronous word-wide RAM. Word stores finish in one cycle. Byte and half
// stores do a read-modify-write. Loads take two edges and sign-extend sub-word
// lanes.
// Optional feature: define MEM_MISALIGN_CHECK_EN to flag and suppress
// misaligned half/word accesses (misalign output); otherwise misalign is tied 0.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  lwsh,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        done,
    output logic [29:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        misalign
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 30;
    localparam int unsigned HW = 16;

    localparam logic [1:0] SZ_WORD     = 2'b00;
    localparam logic [1:0] SZ_BYTE     = 2'b01;
    localparam logic [1:0] SZ_HALF     = 2'b10;
    localparam logic [1:0] SZ_WORD_ALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RMW  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic [HW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   mdr_q, mdr_d;
    logic            done_q, done_d;
    logic            req_fault;
    logic            cur_fault;

    function automatic logic is_word(input logic [1:0] sz);
        return (sz == SZ_WORD) || (sz == SZ_WORD_ALT);
    endfunction

    function automatic logic is_half(input logic [1:0] sz);
        return sz == SZ_HALF;
    endfunction

    // Pick the addressed lane out of a RAM word and sign-extend it.
    function automatic logic [DW-1:0] lane_extract(input logic [DW-1:0] w,
                                                   input logic [1:0]    sz,
                                                   input logic [1:0]    off);
        logic [7:0]    b;
        logic [HW-1:0] h;
        logic [DW-1:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: HW];
        case (sz)
            SZ_BYTE: r = {{24{b[7]}}, b};
            SZ_HALF: r = {{16{h[HW-1]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half lane of a RAM word with store data.
    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] w,
                                                 input logic [HW-1:0] d,
                                                 input logic [1:0]    sz,
                                                 input logic [1:0]    off);
        logic [DW-1:0] r;
        r = w;
        if (sz == SZ_BYTE) begin
            r[{off, 3'b000} +: 8] = d[7:0];
        end else begin
            r[{off[1], 4'b0000} +: HW] = d;
        end
        return r;
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misalign_q, misalign_d;

    assign req_fault = (is_half(lwsh) && addr[0]) ||
                       (is_word(lwsh) && (addr[1:0] != 2'b00));

    // Fault latches on acceptance; flag rises with done, clears on next accepted request.
    always_comb begin
        fault_d    = fault_q;
        misalign_d = misalign_q;
        if (state_q == IDLE) begin
            if (mem_write || mem_read) begin
                fault_d    = req_fault;
                misalign_d = mem_write && is_word(lwsh) && req_fault;
            end
        end else begin
            misalign_d = fault_q;
        end
    end

    // Alignment fault registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
        end
    end

    assign cur_fault = fault_q;
    assign misalign  = misalign_q;
`else
    assign req_fault = 1'b0;
    assign cur_fault = 1'b0;
    assign misalign  = 1'b0;
`endif

    // Next-state, request capture and RAM-side outputs.
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        mdr_d     = mdr_q;
        done_d    = 1'b0;
        busy      = 1'b0;
        ram_addr  = waddr_q;
        ram_we    = 1'b0;
        ram_wdata = wdata;

        case (state_q)
            IDLE: begin
                ram_addr = addr[31:2];
                if (mem_write || mem_read) begin
                    waddr_d = addr[31:2];
                    off_d   = addr[1:0];
                    size_d  = lwsh;
                    wdata_d = wdata[HW-1:0];
                end
                // Write has priority when both requests are raised together.
                if (mem_write) begin
                    if (is_word(lwsh)) begin
                        ram_we = !req_fault;
                        done_d = 1'b1;
                    end else begin
                        state_d = RMW;
                    end
                end else if (mem_read) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
                if (!cur_fault) begin
                    mdr_d = lane_extract(ram_rdata, size_q, off_q);
                end
            end
            RMW: begin
                busy      = 1'b1;
                done_d    = 1'b1;
                state_d   = IDLE;
                ram_we    = !cur_fault;
                ram_wdata = lane_merge(ram_rdata, wdata_q, size_q, off_q);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            ram_we = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            waddr_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
        end
    end

    assign mdr  = mdr_q;
    assign done = done_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL expose: mem_read  input  1  load request from the control FSM (MemRead).
REQ-004 SHALL expose: mem_write  input  1  store request from the control FSM (MemWrite).
REQ-005 SHALL expose: lwsh  input  2  access size: 00 word, 01 byte, 10 half, 11 treated as word.
REQ-006 SHALL expose: addr  input  32  byte address, already muxed by lorD.
REQ-007 SHALL expose: wdata  input  32  store data from register B.
REQ-008 SHALL expose: mdr  output  32  registered, sign-extended load result.
REQ-009 SHALL expose: busy  output  1  high while a multi-cycle access is in flight; the FSM stalls on it.
REQ-010 SHALL expose: done  output  1  one-cycle pulse, registered, on completion of every accepted request.
REQ-011 SHALL expose: ram_addr  output  30  word address to the synchronous RAM.
REQ-012 SHALL expose: ram_we  output  1  RAM write enable.
REQ-013 SHALL expose: ram_wdata  output  32  RAM write word.
REQ-014 SHALL expose: ram_rdata  input  32  RAM read word, valid one cycle after ram_addr is sampled.
REQ-015 SHALL expose: misalign  output  1  registered alignment fault flag; tied 0 when the feature is not compiled in.

Function
REQ-016 States SHALL be IDLE, LOAD, RMW.
REQ-017 In IDLE, ram_addr SHALL equal addr[31:2] combinationally. In LOAD and RMW, it SHALL hold the latched word address.
REQ-018 Requests SHALL be sampled only in IDLE. mem_read/mem_write during LOAD/RMW SHALL be ignored.
REQ-019 If mem_read and mem_write are both high in IDLE, the write SHALL win and the read SHALL be dropped.
REQ-020 Word store: ram_we=1 and ram_wdata=wdata combinationally in IDLE. The write commits at edge E0. done=1 in the cycle after E0. State stays IDLE. busy stays 0.
REQ-021 Byte/half store: at E0, latch wdata, lwsh and addr[1:0], then go to RMW.
REQ-022 In RMW, ram_we=1 and ram_wdata=ram_rdata with only the selected lane replaced from wdata[7:0] or wdata[15:0]. Commit at E1, then go to IDLE. done=1 in the cycle after E1.
REQ-023 Load: at E0, go to LOAD. At E1, mdr <= extracted lane, go to IDLE. done=1 and the new mdr are visible in the cycle after E1 (two-edge latency).
REQ-024 Lanes are little-endian: byte offset 0 = bits[7:0], offset 3 = bits[31:24]; half addr[1]=0 = bits[15:0], 1 = bits[31:16].
REQ-025 Byte and half loads SHALL sign-extend to 32 bits. Word loads pass through unchanged.
REQ-026 busy SHALL be combinational: high exactly in LOAD and RMW.
REQ-027 ram_we SHALL be 0 in LOAD, and in IDLE when there is no store request.
REQ-028 mdr SHALL change only on load completion.

Reset
REQ-029 On rst: state=IDLE, mdr=0, done=0, misalign=0, asynchronously.
REQ-030 An in-flight RMW SHALL be abandoned with no RAM write.
REQ-031 ram_we SHALL be 0 while rst is high.

Configuration
REQ-032 The macro MEM_MISALIGN_CHECK_EN SHALL control the alignment check.
REQ-033 With MEM_MISALIGN_CHECK_EN defined:
- a half access with addr[0]=1, or a word access with addr[1:0]!=0, is a fault;
- on a fault, no RAM write occurs and mdr is unchanged;
- done still pulses at the normal latency;
- misalign=1 from the done cycle until the next accepted request.
REQ-034 Without MEM_MISALIGN_CHECK_EN:
- addr[1:0] is ignored for word accesses;
- addr[0] is ignored for half accesses;
- misalign is constant 0.

Verification
REQ-035 RAM[1]=0x8899AABB; lb addr=0x6 -> mdr=0xFFFFFF99 and done pulse 2 edges after request; then lbu-free lh addr=0x4 -> mdr=0xFFFFAABB.
REQ-036 RAM[2]=0x11223344; sb addr=0x9 wdata=0x000000EE -> busy high for one cycle, RAM[2]=0x1122EE44, done after E1.
REQ-037 sw addr=0xC wdata=0xDEADBEEF -> ram_we in the request cycle, RAM[3]=0xDEADBEEF, busy never high, done next cycle.
REQ-038 mem_read=mem_write=1 at addr 0x10 -> write performed, mdr unchanged. Request pulsed during busy -> ignored, no extra done.
REQ-039 rst asserted during RMW of sh addr=0x2 -> no RAM write, state IDLE, mdr=0, done=0.
REQ-040 With MEM_MISALIGN_CHECK_EN: sh addr=0x3 -> RAM unchanged, misalign=1, done pulses. Without it: the same access writes bits[31:16].
